// File: rtl/display_scan_decoder.sv
// display_scan_decoder: watches a multiplexed 8-digit seven-segment bus and
// rebuilds the displayed word. Each strobe must stay stable for a
// number of cycles before it is accepted. The segment pattern is then
// decoded back to a 4-bit code. Complete frames and abandoned frames are
// reported with one-cycle pulses.
module display_scan_decoder #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  an,
  input  logic [7:0]  seg,
  output logic [31:0] digits,
  output logic [7:0]  digit_err,
  output logic [7:0]  captured,
  output logic        frame_valid,
  output logic        frame_timeout
);

  localparam int CW = $clog2(STABLE_CYCLES + 2);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  localparam logic [CW-1:0] CNT_STABLE = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_SAT    = CW'(STABLE_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_EMIT    = 2'd2;

  logic [7:0]    s_an_reg;
  logic [7:0]    s_seg_reg;
  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;
  logic [1:0]    state_reg;
  logic [1:0]    state_next;
  logic [TW-1:0] timer_reg;
  logic [TW-1:0] timer_next;
  logic [7:0]    captured_reg;
  logic [7:0]    captured_next;
  logic          timeout_reg;
  logic          timeout_next;
  logic [31:0]   digits_reg;
  logic [31:0]   digits_next;
  logic [7:0]    err_reg;
  logic [7:0]    err_next;

  logic          sample_same;
  logic          stable_hit;
  logic [7:0]    sel;
  logic          sel_single;
  logic          commit;
  logic [7:0]    digit_wr;
  logic [3:0]    dec_code;
  logic          dec_invalid;

  // A strobe is only meaningful when exactly one anode is driven low.
  assign sample_same = ({an, seg} == {s_an_reg, s_seg_reg});
  assign stable_hit  = sample_same && (cnt_reg == CNT_STABLE);
  assign sel         = ~s_an_reg;
  assign sel_single  = (sel != 8'h00) && ((sel & (sel - 8'd1)) == 8'h00);
  assign commit      = stable_hit && sel_single;

  // Stability counter: restart on any change, saturate once the window is used up.
  always_comb begin
    cnt_next = cnt_reg;
    if (!sample_same) begin
      cnt_next = CW'(1);
    end else if (cnt_reg != CNT_SAT) begin
      cnt_next = cnt_reg + CW'(1);
    end
  end

  // Input sample register and stability counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      s_an_reg  <= 8'hFF;
      s_seg_reg <= 8'h00;
      cnt_reg   <= '0;
    end else begin
      s_an_reg  <= an;
      s_seg_reg <= seg;
      cnt_reg   <= cnt_next;
    end
  end

  // Segment pattern to code; DP takes part in the match, so a lit DP on a digit glyph is an error.
  always_comb begin
    dec_code    = 4'h0;
    dec_invalid = 1'b0;
    case (s_seg_reg)
      8'hFC: dec_code = 4'h0;
      8'h60: dec_code = 4'h1;
      8'hDA: dec_code = 4'h2;
      8'hF2: dec_code = 4'h3;
      8'h66: dec_code = 4'h4;
      8'hB6: dec_code = 4'h5;
      8'hBE: dec_code = 4'h6;
      8'hE0: dec_code = 4'h7;
      8'hFE: dec_code = 4'h8;
      8'hF6: dec_code = 4'h9;
      8'h9E: dec_code = 4'hF;
      8'h01: dec_code = 4'hA;
      default: dec_invalid = 1'b1;
    endcase
  end

  // Per-digit write lanes: only the strobed digit is updated on a commit.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      assign digit_wr[gi]          = commit & sel[gi];
      assign digits_next[4*gi +: 4] = digit_wr[gi] ? dec_code : digits_reg[4*gi +: 4];
      assign err_next[gi]          = digit_wr[gi] ? dec_invalid : err_reg[gi];
    end
  endgenerate

  // Frame tracking: collect strobes, emit on a full set, abandon after a long silence.
  always_comb begin
    state_next    = state_reg;
    timer_next    = timer_reg;
    captured_next = captured_reg;
    timeout_next  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        timer_next = '0;
        if (commit) begin
          captured_next = sel;
          state_next    = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (commit) begin
          timer_next    = '0;
          captured_next = captured_reg | sel;
          if ((captured_reg | sel) == 8'hFF) begin
            state_next = ST_EMIT;
          end
        end else if (timer_reg == TIMER_LAST) begin
          timer_next    = '0;
          captured_next = 8'h00;
          timeout_next  = 1'b1;
          state_next    = ST_IDLE;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end
      ST_EMIT: begin
        timer_next = '0;
        if (commit) begin
          captured_next = sel;
          state_next    = ST_COLLECT;
        end else begin
          captured_next = 8'h00;
          state_next    = ST_IDLE;
        end
      end
      default: begin
        timer_next    = '0;
        captured_next = 8'h00;
        state_next    = ST_IDLE;
      end
    endcase
  end

  // State, frame bookkeeping and decoded digit storage.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      timer_reg    <= '0;
      captured_reg <= 8'h00;
      timeout_reg  <= 1'b0;
      digits_reg   <= 32'h0;
      err_reg      <= 8'h00;
    end else begin
      state_reg    <= state_next;
      timer_reg    <= timer_next;
      captured_reg <= captured_next;
      timeout_reg  <= timeout_next;
      digits_reg   <= digits_next;
      err_reg      <= err_next;
    end
  end

  assign digits        = digits_reg;
  assign digit_err     = err_reg;
  assign captured      = captured_reg;
  assign frame_valid   = (state_reg == ST_EMIT);
  assign frame_timeout = timeout_reg;

endmodule

// File: tb/tb_display_scan_decoder.sv
// tb_display_scan_decoder: drives strobes onto the scan bus and compares the
// decoder against a behavioural model built on run lengths and silence counts.
module tb_display_scan_decoder;

  localparam int S = 4;
  localparam int T = 1024;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  an    = 8'hFF;
  logic [7:0]  seg   = 8'h00;
  logic [31:0] digits;
  logic [7:0]  digit_err;
  logic [7:0]  captured;
  logic        frame_valid;
  logic        frame_timeout;

  display_scan_decoder #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clock(clock), .reset(reset), .an(an), .seg(seg),
    .digits(digits), .digit_err(digit_err), .captured(captured),
    .frame_valid(frame_valid), .frame_timeout(frame_timeout)
  );

  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;

  // Glyph table indexed by code; only codes 0-9, A and F have a glyph.
  logic [7:0]  glyph_tab [0:15] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                    8'hFE, 8'hF6, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h9E};
  logic [15:0] glyph_ok = 16'b1000_0111_1111_1111;

  // Reference model state.
  logic [15:0] m_prev;
  int          m_run;
  int          m_dig [8];
  bit          m_err [8];
  bit   [7:0]  m_cap;
  bit          m_coll;
  bit          m_emit;
  bit          m_tout;
  int          m_since;
  int          exp_valid = 0;
  int          exp_tout  = 0;
  int          obs_valid = 0;
  int          obs_tout  = 0;
  int          obs_both  = 0;

  function automatic int model_code(input logic [7:0] p);
    for (int v = 0; v < 16; v++) begin
      if (glyph_ok[v] && glyph_tab[v] == p) return v;
    end
    return -1;
  endfunction

  function automatic logic [31:0] exp_digits();
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[4*i +: 4] = m_dig[i][3:0];
    return r;
  endfunction

  function automatic logic [7:0] exp_err();
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = m_err[i];
    return r;
  endfunction

  // Model one rising edge using the inputs present at that edge.
  task automatic model_edge();
    bit commit, new_emit, new_tout;
    int zeros, idx, code;
    if (reset) begin
      m_prev = 16'hFF00; m_run = 0; m_cap = 0; m_coll = 0;
      m_emit = 0; m_tout = 0; m_since = 0;
      for (int i = 0; i < 8; i++) begin m_dig[i] = 0; m_err[i] = 0; end
    end else begin
      if ({an, seg} == m_prev) m_run++;
      else m_run = 1;
      m_prev = {an, seg};
      zeros = 0; idx = 0;
      for (int i = 0; i < 8; i++) if (!an[i]) begin zeros++; idx = i; end
      commit = (m_run == S + 1) && (zeros == 1);
      new_emit = 0; new_tout = 0;
      if (m_emit) begin
        m_cap = 0; m_coll = 0;
      end else if (m_coll && !commit) begin
        m_since++;
        if (m_since == T) begin
          m_coll = 0; m_cap = 0; new_tout = 1; exp_tout++;
        end
      end
      if (commit) begin
        code = model_code(seg);
        m_dig[idx] = (code < 0) ? 0 : code;
        m_err[idx] = (code < 0);
        m_cap[idx] = 1'b1;
        m_since = 0;
        if (m_cap == 8'hFF) begin
          new_emit = 1; exp_valid++; m_coll = 0;
        end else begin
          m_coll = 1;
        end
      end
      m_emit = new_emit;
      m_tout = new_tout;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    if (frame_valid === 1'b1) obs_valid++;
    if (frame_timeout === 1'b1) obs_tout++;
    if (frame_valid === 1'b1 && frame_timeout === 1'b1) obs_both++;
  endtask

  task automatic hold(input logic [7:0] a, input logic [7:0] sg, input int n);
    an = a; seg = sg;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) begin
      an = 8'($urandom); seg = 8'($urandom);
      tick();
    end
    n_cmp++; if (digits !== 32'h0) begin n_fail++; $display("FAIL reset_digits got=%h want=0", digits); end
    n_cmp++; if (digit_err !== 8'h0) begin n_fail++; $display("FAIL reset_err got=%h want=0", digit_err); end
    n_cmp++; if (captured !== 8'h0) begin n_fail++; $display("FAIL reset_captured got=%h want=0", captured); end
    n_cmp++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b want=0", frame_valid); end
    n_cmp++; if (frame_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got=%b want=0", frame_timeout); end
    reset = 1'b0;
    hold(8'hFF, 8'h00, 1);
    n_cmp++; if (frame_valid !== 1'b0 || frame_timeout !== 1'b0) begin
      n_fail++; $display("FAIL release_pulse got=%b%b want=00", frame_valid, frame_timeout);
    end
    $display("test_reset done: compared=%0d mismatched=%0d", n_cmp, n_fail);
  endtask

  task automatic test_full_frame();
    int v0;
    hold(8'hFF, 8'h00, 3);
    v0 = obs_valid;
    for (int i = 0; i < 8; i++) begin
      hold(~(8'h01 << i), glyph_tab[i], 6);
      if (i == 6) begin
        n_cmp++; if (captured !== 8'h7F) begin n_fail++; $display("FAIL full_partial_cap got=%h want=7f", captured); end
      end
    end
    hold(8'hFF, 8'h00, 2);
    n_cmp++; if (digits !== 32'h76543210) begin n_fail++; $display("FAIL full_digits got=%h want=76543210", digits); end
    n_cmp++; if (digit_err !== 8'h00) begin n_fail++; $display("FAIL full_err got=%h want=00", digit_err); end
    n_cmp++; if (obs_valid - v0 !== 1) begin n_fail++; $display("FAIL full_valid_pulses got=%0d want=1", obs_valid - v0); end
    n_cmp++; if (captured !== 8'h00) begin n_fail++; $display("FAIL full_cap_clear got=%h want=00", captured); end
    $display("test_full_frame done: digits=%h valid_pulses=%0d", digits, obs_valid - v0);
  endtask

  task automatic test_glitch();
    logic [3:0] d2;
    logic [7:0] c0;
    int n, d;
    d2 = digits[11:8]; c0 = captured;
    hold(8'hFB, 8'hB6, S);
    hold(8'hFF, 8'h00, 1);
    n_cmp++; if (digits[11:8] !== d2) begin n_fail++; $display("FAIL glitch_digit got=%h want=%h", digits[11:8], d2); end
    n_cmp++; if (captured !== c0) begin n_fail++; $display("FAIL glitch_cap got=%h want=%h", captured, c0); end
    hold(8'hFB, 8'hB6, S + 1);
    hold(8'hFF, 8'h00, 1);
    n_cmp++; if (digits[11:8] !== 4'h5) begin n_fail++; $display("FAIL glitch_accept got=%h want=5", digits[11:8]); end
    n_cmp++; if (captured[2] !== 1'b1) begin n_fail++; $display("FAIL glitch_accept_cap got=%h want bit2", captured); end
    for (int k = 0; k < 10; k++) begin
      n = $urandom_range(1, S + 2);
      d = $urandom_range(0, 7);
      hold(~(8'h01 << d), glyph_tab[$urandom_range(0, 9)], n);
      hold(8'hFF, 8'h00, 1);
      n_cmp++; if (captured !== m_cap) begin n_fail++; $display("FAIL glitch_rand_cap len=%0d got=%h want=%h", n, captured, m_cap); end
      n_cmp++; if (digits !== exp_digits()) begin n_fail++; $display("FAIL glitch_rand_dig len=%0d got=%h want=%h", n, digits, exp_digits()); end
    end
    $display("test_glitch done: digits=%h captured=%h", digits, captured);
  endtask

  task automatic test_codes();
    hold(8'hF7, 8'hFF, S + 1);
    hold(8'hFF, 8'h00, 1);
    n_cmp++; if (digit_err[3] !== 1'b1) begin n_fail++; $display("FAIL code_err_flag got=%b want=1", digit_err[3]); end
    n_cmp++; if (digits[15:12] !== 4'h0) begin n_fail++; $display("FAIL code_err_digit got=%h want=0", digits[15:12]); end
    hold(8'hEF, 8'h9E, S + 1);
    hold(8'hFF, 8'h00, 1);
    n_cmp++; if (digits[19:16] !== 4'hF || digit_err[4] !== 1'b0) begin
      n_fail++; $display("FAIL code_e_glyph got=%h/%b want=f/0", digits[19:16], digit_err[4]);
    end
    hold(8'hDF, 8'h01, S + 1);
    hold(8'hFF, 8'h00, 1);
    n_cmp++; if (digits[23:20] !== 4'hA || digit_err[5] !== 1'b0) begin
      n_fail++; $display("FAIL code_blank got=%h/%b want=a/0", digits[23:20], digit_err[5]);
    end
    $display("test_codes done: digits=%h err=%h", digits, digit_err);
  endtask

  task automatic test_timeout();
    int v0, t0;
    hold(8'hFF, 8'h00, T + 80);
    n_cmp++; if (captured !== 8'h00) begin n_fail++; $display("FAIL tout_drain got=%h want=00", captured); end
    v0 = obs_valid; t0 = obs_tout;
    for (int i = 0; i < 4; i++) hold(~(8'h01 << i), glyph_tab[i], 6);
    hold(8'hFF, 8'h00, T - 2);
    n_cmp++; if (captured !== 8'h0F || obs_tout - t0 !== 0) begin
      n_fail++; $display("FAIL tout_early cap=%h pulses=%0d want=0f/0", captured, obs_tout - t0);
    end
    hold(8'hFF, 8'h00, 1);
    n_cmp++; if (frame_timeout !== 1'b1) begin n_fail++; $display("FAIL tout_edge got=%b want=1", frame_timeout); end
    n_cmp++; if (captured !== 8'h00) begin n_fail++; $display("FAIL tout_cap got=%h want=00", captured); end
    hold(8'hFF, 8'h00, 1);
    n_cmp++; if (frame_timeout !== 1'b0 || obs_tout - t0 !== 1) begin
      n_fail++; $display("FAIL tout_single level=%b pulses=%0d want=0/1", frame_timeout, obs_tout - t0);
    end
    n_cmp++; if (obs_valid - v0 !== 0) begin n_fail++; $display("FAIL tout_no_valid got=%0d want=0", obs_valid - v0); end
    n_cmp++; if (digits[15:0] !== 16'h3210) begin n_fail++; $display("FAIL tout_retain got=%h want=3210", digits[15:0]); end
    $display("test_timeout done: timeout_pulses=%0d", obs_tout - t0);
  endtask

  task automatic test_illegal_and_reset();
    logic [7:0]  c0;
    logic [31:0] dg0;
    int v0;
    c0 = captured; dg0 = digits;
    hold(8'hFC, 8'hFC, 10);
    hold(8'h7E, 8'h60, 10);
    hold(8'hFF, 8'h00, 1);
    n_cmp++; if (captured !== c0 || digits !== dg0) begin
      n_fail++; $display("FAIL illegal_an cap=%h dig=%h want=%h/%h", captured, digits, c0, dg0);
    end
    for (int i = 0; i < 5; i++) hold(~(8'h01 << i), glyph_tab[7 - i], 6);
    n_cmp++; if (captured !== 8'h1F) begin n_fail++; $display("FAIL mid_cap got=%h want=1f", captured); end
    reset = 1'b1;
    hold(8'hFF, 8'h00, 1);
    reset = 1'b0;
    n_cmp++; if (digits !== 32'h0 || digit_err !== 8'h0 || captured !== 8'h0) begin
      n_fail++; $display("FAIL mid_reset dig=%h err=%h cap=%h want=0", digits, digit_err, captured);
    end
    n_cmp++; if (frame_valid !== 1'b0 || frame_timeout !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_pulse got=%b%b want=00", frame_valid, frame_timeout);
    end
    v0 = obs_valid;
    for (int i = 0; i < 8; i++) hold(~(8'h01 << i), glyph_tab[i], 6);
    hold(8'hFF, 8'h00, 2);
    n_cmp++; if (obs_valid - v0 !== 1 || digits !== 32'h76543210) begin
      n_fail++; $display("FAIL post_reset_frame pulses=%0d dig=%h want=1/76543210", obs_valid - v0, digits);
    end
    $display("test_illegal_and_reset done: digits=%h", digits);
  endtask

  task automatic test_back_to_back();
    int perm [8];
    int v0, j, tmp;
    v0 = obs_valid;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 8; i++) perm[i] = i;
      for (int i = 7; i > 0; i--) begin
        j = $urandom_range(0, i); tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
      end
      for (int i = 0; i < 8; i++) hold(~(8'h01 << perm[i]), glyph_tab[$urandom_range(0, 9)], S + 1);
    end
    hold(8'hFF, 8'h00, 2);
    n_cmp++; if (obs_valid - v0 !== 2) begin n_fail++; $display("FAIL b2b_pulses got=%0d want=2", obs_valid - v0); end
    n_cmp++; if (digits !== exp_digits()) begin n_fail++; $display("FAIL b2b_digits got=%h want=%h", digits, exp_digits()); end
    $display("test_back_to_back done: pulses=%0d digits=%h", obs_valid - v0, digits);
  endtask

  task automatic test_random();
    logic [7:0] a, sg;
    int r, n, v;
    for (int w = 0; w < 400; w++) begin
      r = $urandom_range(0, 9);
      if (r < 8) a = ~(8'h01 << $urandom_range(0, 7));
      else if (r == 8) a = 8'hFF;
      else a = 8'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        v = $urandom_range(0, 11);
        sg = glyph_tab[(v < 10) ? v : ((v == 10) ? 10 : 15)];
      end else begin
        sg = 8'($urandom);
      end
      n = $urandom_range(1, 8);
      an = a; seg = sg;
      repeat (n) begin
        tick();
        n_cmp++; if (frame_valid !== m_emit) begin n_fail++; $display("FAIL rand_valid w=%0d got=%b want=%b", w, frame_valid, m_emit); end
        n_cmp++; if (frame_timeout !== m_tout) begin n_fail++; $display("FAIL rand_tout w=%0d got=%b want=%b", w, frame_timeout, m_tout); end
      end
      n_cmp++; if (captured !== m_cap) begin n_fail++; $display("FAIL rand_cap w=%0d got=%h want=%h", w, captured, m_cap); end
      n_cmp++; if (digits !== exp_digits()) begin n_fail++; $display("FAIL rand_dig w=%0d got=%h want=%h", w, digits, exp_digits()); end
      n_cmp++; if (digit_err !== exp_err()) begin n_fail++; $display("FAIL rand_err w=%0d got=%h want=%h", w, digit_err, exp_err()); end
    end
    hold(8'hFF, 8'h00, T + 20);
    n_cmp++; if (obs_valid !== exp_valid) begin n_fail++; $display("FAIL total_valid got=%0d want=%0d", obs_valid, exp_valid); end
    n_cmp++; if (obs_tout !== exp_tout) begin n_fail++; $display("FAIL total_tout got=%0d want=%0d", obs_tout, exp_tout); end
    n_cmp++; if (obs_both !== 0) begin n_fail++; $display("FAIL pulse_overlap got=%0d want=0", obs_both); end
    $display("test_random done: frames=%0d timeouts=%0d", obs_valid, obs_tout);
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_glitch();
    test_codes();
    test_timeout();
    test_illegal_and_reset();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/display_scan_decoder.md
# display_scan_decoder

Receive-side counterpart of the display controller. Monitors a multiplexed 8-digit seven-segment bus (active-low anodes plus shared segment lines), debounces each strobe, and decodes the segment pattern back to the 4-bit digit code. It rebuilds the full 8-digit word, flags patterns it cannot decode, and reports complete or abandoned frames. The block feeds the display self-test and loopback checks.

## Interface
- STABLE_CYCLES, 4: consecutive identical samples required before a strobe is accepted (legal range ≥2).
- TIMEOUT_CYCLES, 1024: idle cycles since the last accepted strobe that abort a partial frame (≥2).

- clock  in  1  sole clock; all logic updates on the rising edge.
- reset  in  1  synchronous, active-high.
- an  in  8  anode enables, active-low; an[i]=0 selects digit i.
- seg  in  8  segment lines, active-high; seg[7]=A, seg[6]=B … seg[1]=G, seg[0]=DP.
- digits  out  8×4  decoded code per digit (digits[i] = digit i).
- digit_err  out  8  digit_err[i]=1: the last accepted pattern for digit i was undecodable.
- captured  out  8  digits accepted in the current frame.
- frame_valid  out  1  one-cycle pulse when all 8 digits are accepted.
- frame_timeout  out  1  one-cycle pulse when a partial frame is abandoned.

## Operation
- **Input stage.** {an, seg} is registered every cycle into a sample register s.
- **Stability counter cnt.**
  - If the new sample equals s: cnt increments, saturating at STABLE_CYCLES+1.
  - Otherwise: cnt is set to 1.
- **Accept (commit).** Happens on the edge where the sample still equals s and cnt==STABLE_CYCLES. That edge also sets cnt to STABLE_CYCLES+1, so one stable window produces exactly one commit.
- **Legal strobe.** A commit is legal only if s.an has exactly one zero bit, at index i. For an all-ones or multi-zero an, no commit happens and the counter still runs.
- **Commit action.** digits[i] ← decode(s.seg), digit_err[i] ← invalid, captured[i] ← 1. Re-committing the same digit overwrites it.
- **Decode (full 8-bit match, DP included):**
  - FC→0, 60→1, DA→2, F2→3, 66→4, B6→5, BE→6, E0→7, FE→8, F6→9.
  - 9E→F (the "E" glyph).
  - 01→A (the blank pattern, DP only).
  - Any other pattern → code 0, invalid=1.
- **FSM:**
  - IDLE: captured==0, timer held at 0. A commit → COLLECT.
  - COLLECT: timer increments each cycle and clears to 0 on any commit.
    - A commit that makes captured==FF → EMIT.
    - Timer reaching TIMEOUT_CYCLES−1 with no commit → IDLE. That transition pulses frame_timeout and clears captured.
  - EMIT: lasts one cycle. frame_valid=1 (Moore output), captured cleared → IDLE.
    - A commit during EMIT: captured becomes only bit i and the next state is COLLECT.
- frame_timeout does not alter digits or digit_err.

## Timing
- Reset values:
  - digits all 0, digit_err 0, captured 0, frame_valid 0, frame_timeout 0.
  - State IDLE, cnt 0, timer 0, s.an=FF, s.seg=00.
- Reset mid-frame discards all captured state within the reset cycle.
- **Commit latency.** A new {an, seg} first sampled at edge t0 and held through edge t0+STABLE_CYCLES produces updated digits/digit_err/captured visible after edge t0+STABLE_CYCLES. The minimum strobe width is STABLE_CYCLES+1 cycles; shorter strobes are ignored.
- **frame_valid** is high for the one cycle after the completing commit edge.
- **frame_timeout** is high for the one cycle after the edge that leaves COLLECT. With no commits after the last one at edge tc, that exit happens at edge tc+TIMEOUT_CYCLES.
- frame_valid and frame_timeout are never high together.
- The block has no back-pressure. Outputs hold their value between commits.

## Test plan
- **Reset.** Assert reset 2 cycles with random inputs → all outputs 0, and no pulse in the first cycle after release.
- **Full frame.** STABLE=4; scan an[i]=0 with the pattern for digit value i (i=0..7), 6 cycles each → digits={7,6,5,4,3,2,1,0}, digit_err=00, exactly one frame_valid pulse, captured returns to 00.
- **Glitch rejection.** Pattern for 5 held 4 cycles on digit 2, then changed → no commit, digits[2] and captured unchanged. Holding 5 cycles → digits[2]=5.
- **Error and special codes.** seg=FF on digit 3 → digit_err[3]=1, digits[3]=0. seg=9E → F. seg=01 → A with no error.
- **Timeout.** Commit digits 0–3, then hold an=FF for 1024 cycles → single frame_timeout pulse, captured=00, digits[0..3] retained, frame_valid never asserted.
- **Illegal anodes and reset mid-frame.** an=FC held 10 cycles → no commit. After 5 commits, pulse reset → all outputs 0, and a following full scan produces a normal frame_valid.
